// File: rtl/ula_rpn_pkg.sv
// Shared types for the RPN stack ALU: opcodes, FSM states, result flags and
// small opcode-decoding helpers.
package ula_rpn_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_WRITE = 2'b10
    } state_e;

    typedef struct packed {
        logic cout;
        logic ov;
        logic zero;
        logic resto;
    } flags_t;

    function automatic logic is_seq(op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // NOT is the only unary opcode; everything else consumes two entries.
    function automatic logic [1:0] op_args(op_e op);
        return (op == OP_NOT) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/ula_rpn_pilha_if.sv
// Front-panel / display bundle of the RPN stack ALU. With REUSO_EN defined
// the bundle carries the extra `reuso` request (push last result).
interface ula_rpn_pilha_if
    import ula_rpn_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int NW    = $clog2(DEPTH + 1)
) ();

    // op is taken on a cycle where op_valid && op_ready; op_ready is high only
    // in IDLE, and res_valid is a single-cycle pulse when the result lands on
    // the stack.
    logic [W-1:0]  dado_in;
    logic          push;
    logic          op_valid;
    logic [2:0]    op;
`ifdef REUSO_EN
    logic          reuso;
`endif
    logic          op_ready;
    logic          res_valid;
    logic [W-1:0]  resultado;
    logic [W-1:0]  topo;
    logic [NW-1:0] nivel;
    logic          cout;
    logic          ov;
    logic          zero;
    logic          erro;
    logic          resto_led;
    logic          ocupado;
    state_e        dbg_estado;

    modport slave (
`ifdef REUSO_EN
        input  reuso,
`endif
        input  dado_in, push, op_valid, op,
        output op_ready, res_valid, resultado, topo, nivel,
        output cout, ov, zero, erro, resto_led, ocupado, dbg_estado
    );

    modport master (
`ifdef REUSO_EN
        output reuso,
`endif
        output dado_in, push, op_valid, op,
        input  op_ready, res_valid, resultado, topo, nivel,
        input  cout, ov, zero, erro, resto_led, ocupado, dbg_estado
    );

endinterface

// File: rtl/mult_div_seq.sv
// Shared sequential multiplier (shift-add) / restoring divider, one bit per
// cycle for W cycles. Product / remainder:quotient share one 2W register.
module mult_div_seq #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic         modo,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result,
    output logic         hi_nz,
    output logic         rem_nz
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] p_q, p_d;
    logic [W-1:0]   m_q, m_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           modo_q, modo_d;

    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   div_rem;

    always_comb begin
        mul_sum   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
        div_trial = {p_q[2*W-1:W], p_q[W-1]};
        div_ge    = div_trial >= {1'b0, m_q};
        // When div_ge holds the difference is below the divisor, so W bits suffice.
        div_rem   = div_ge ? (div_trial[W-1:0] - m_q) : div_trial[W-1:0];
    end

    assign done = busy_q && (cnt_q == CW'(W - 1));

    always_comb begin
        p_d    = p_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        modo_d = modo_q;
        if (start) begin
            modo_d = modo;
            p_d    = {{W{1'b0}}, (modo ? a : b)};
            m_d    = modo ? b : a;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            p_d   = modo_q ? {div_rem, p_q[W-2:0], div_ge} : {mul_sum, p_q[W-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            modo_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            modo_q <= modo_d;
        end
    end

    assign result = p_q[W-1:0];
    assign hi_nz  = !modo_q && (|p_q[2*W-1:W]);
    assign rem_nz = modo_q && (|p_q[2*W-1:W]);

endmodule

// File: rtl/ula_rpn_pilha.sv
// RPN ALU with a DEPTH-entry operand stack and shared sequential MUL/DIV.
// Optional REUSO_EN adds a `reuso` request that pushes the last result.
module ula_rpn_pilha
    import ula_rpn_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int NW    = $clog2(DEPTH + 1)
) (
    input  logic clock,
    input  logic rst_n,
    ula_rpn_pilha_if.slave bus
);

    state_e        state_q, state_d;
    logic [W-1:0]  stk_q [DEPTH];
    logic [W-1:0]  stk_d [DEPTH];
    logic [NW-1:0] nivel_q, nivel_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    op_e           op_q, op_d;
    logic [W-1:0]  resultado_q, resultado_d;
    flags_t        flags_q, flags_d;
    logic          res_valid_q, res_valid_d;
    logic          erro_q, erro_d;

    op_e           op_in;
    logic [W-1:0]  topo, opnd_a;
    logic          underflow, div_zero;
    logic          push_req, push_clash;
    logic [W-1:0]  push_data;
    logic          wr_en;
    logic [NW-1:0] wr_idx;
    logic [W-1:0]  wr_data;
    logic          md_start, md_done, md_hi_nz, md_rem_nz;
    logic [W-1:0]  md_result;
    logic [W:0]    sum_ext, dif_ext;
    logic [W-1:0]  alu_res;
    flags_t        alu_flags;

    assign op_in = op_e'(bus.op);

    always_comb begin
        topo   = '0;
        opnd_a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (nivel_q == NW'(i + 1)) topo   = stk_q[i];
            if (nivel_q == NW'(i + 2)) opnd_a = stk_q[i];
        end
    end

    assign underflow = nivel_q < NW'(op_args(op_in));
    assign div_zero  = (op_in == OP_DIV) && (topo == '0);

    mult_div_seq #(.W(W)) u_mult_div (
        .clock  (clock),
        .rst_n  (rst_n),
        .start  (md_start),
        .modo   (op_in == OP_DIV),
        .a      (opnd_a),
        .b      (topo),
        .done   (md_done),
        .result (md_result),
        .hi_nz  (md_hi_nz),
        .rem_nz (md_rem_nz)
    );

    always_comb begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q};
        dif_ext   = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = '0;
        alu_flags = '0;
        case (op_q)
            OP_ADD: begin
                alu_res        = sum_ext[W-1:0];
                alu_flags.cout = sum_ext[W];
                alu_flags.ov   = (a_q[W-1] == b_q[W-1]) && (sum_ext[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                alu_res        = dif_ext[W-1:0];
                alu_flags.cout = dif_ext[W];
                alu_flags.ov   = (a_q[W-1] != b_q[W-1]) && (dif_ext[W-1] != a_q[W-1]);
            end
            OP_MUL: begin
                alu_res      = md_result;
                alu_flags.ov = md_hi_nz;
            end
            OP_DIV: begin
                alu_res         = md_result;
                alu_flags.resto = md_rem_nz;
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~b_q;
            default: alu_res = '0;
        endcase
        alu_flags.zero = (alu_res == '0);
    end

    always_comb begin
        state_d     = state_q;
        stk_d       = stk_q;
        nivel_d     = nivel_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        resultado_d = resultado_q;
        flags_d     = flags_q;
        res_valid_d = 1'b0;
        erro_d      = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_data     = '0;
        md_start    = 1'b0;
`ifdef REUSO_EN
        push_req    = bus.push || bus.reuso;
        push_clash  = bus.push && bus.reuso;
        push_data   = bus.reuso ? resultado_q : bus.dado_in;
`else
        push_req    = bus.push;
        push_clash  = 1'b0;
        push_data   = bus.dado_in;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    // An op always wins; any push in the same cycle is refused.
                    if (push_req) erro_d = 1'b1;
                    if (underflow || div_zero) begin
                        erro_d = 1'b1;
                    end else begin
                        a_d      = opnd_a;
                        b_d      = topo;
                        op_d     = op_in;
                        md_start = is_seq(op_in);
                        state_d  = is_seq(op_in) ? ST_EXEC : ST_WRITE;
                    end
                end else if (push_req) begin
                    if (push_clash) erro_d = 1'b1;
                    if (nivel_q == NW'(DEPTH)) begin
                        erro_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = nivel_q;
                        wr_data = push_data;
                        nivel_d = nivel_q + NW'(1);
                    end
                end
            end
            ST_EXEC: begin
                if (push_req) erro_d = 1'b1;
                if (md_done)  state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (push_req) erro_d = 1'b1;
                // Stack was frozen since accept, so the operands are still in place.
                wr_en         = 1'b1;
                wr_idx        = nivel_q - NW'(op_args(op_q));
                wr_data       = alu_res;
                nivel_d       = wr_idx + NW'(1);
                resultado_d   = alu_res;
                flags_d.cout  = alu_flags.cout;
                flags_d.ov    = alu_flags.ov;
                flags_d.zero  = alu_flags.zero;
                if (op_q == OP_DIV) flags_d.resto = alu_flags.resto;
                res_valid_d   = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_idx == NW'(i))) stk_d[i] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stk_q       <= '{default: '0};
            nivel_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            resultado_q <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stk_q       <= stk_d;
            nivel_q     <= nivel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            resultado_q <= resultado_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            erro_q      <= erro_d;
        end
    end

    assign bus.op_ready   = (state_q == ST_IDLE);
    assign bus.res_valid  = res_valid_q;
    assign bus.resultado  = resultado_q;
    assign bus.topo       = topo;
    assign bus.nivel      = nivel_q;
    assign bus.cout       = flags_q.cout;
    assign bus.ov         = flags_q.ov;
    assign bus.zero       = flags_q.zero;
    assign bus.resto_led  = flags_q.resto;
    assign bus.erro       = erro_q;
    assign bus.ocupado    = (state_q == ST_EXEC);
    assign bus.dbg_estado = state_q;

endmodule

// File: tb/tb_ula_rpn_pilha.sv
// Directed plus random bench for ula_rpn_pilha against a queue-based
// reference model of the stack and plain-integer arithmetic.
module tb_ula_rpn_pilha;
    import ula_rpn_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int NW    = $clog2(DEPTH + 1);
    localparam int FULL  = 1 << W;
    localparam int HALF  = 1 << (W - 1);

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    ula_rpn_pilha_if #(.W(W), .DEPTH(DEPTH), .NW(NW)) bus ();

    ula_rpn_pilha #(.W(W), .DEPTH(DEPTH), .NW(NW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int mdl_stk[$];
    int mdl_r = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_stack(input string tag);
        check({tag, "_nivel"}, 32'(bus.nivel), mdl_stk.size());
        check({tag, "_topo"}, 32'(bus.topo), (mdl_stk.size() > 0) ? mdl_stk[$] : 0);
    endtask

    task automatic check_reset_values();
        check("rst_nivel",     32'(bus.nivel),     0);
        check("rst_topo",      32'(bus.topo),      0);
        check("rst_resultado", 32'(bus.resultado), 0);
        check("rst_flags",     {28'd0, bus.cout, bus.ov, bus.zero, bus.resto_led}, 0);
        check("rst_op_ready",  32'(bus.op_ready),  1);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_ocupado",   32'(bus.ocupado),   0);
        check("rst_erro",      32'(bus.erro),      0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        mdl_stk.delete();
        exp_q.delete();
        mdl_r = 0;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic do_push(input int v);
        bit exp_err;
        exp_err = mdl_stk.size() >= DEPTH;
        @(negedge clock);
        bus.dado_in = W'(v);
        bus.push    = 1'b1;
        @(negedge clock);
        bus.push = 1'b0;
        if (!exp_err) mdl_stk.push_back(v % FULL);
        check("push_erro", 32'(bus.erro), 32'(exp_err));
        check_stack("push");
    endtask

    task automatic run_op(input int o, input bit with_push);
        int a, b, res, cf, vf, need, full, sa, sb, lat, busy_cnt;
        bit rej, seq;
        logic [W-1:0] exp_res;
        need = (o == 7) ? 1 : 2;
        seq  = (o == 2) || (o == 3);
        rej  = mdl_stk.size() < need;
        a = 0;
        b = 0;
        if (!rej) begin
            b = mdl_stk[mdl_stk.size() - 1];
            if (need == 2) a = mdl_stk[mdl_stk.size() - 2];
            if (o == 3 && b == 0) rej = 1'b1;
        end
        @(negedge clock);
        bus.op       = 3'(o);
        bus.op_valid = 1'b1;
        bus.push     = with_push;
        bus.dado_in  = W'(90);
        @(negedge clock);
        bus.op_valid = 1'b0;
        bus.push     = 1'b0;
        check("op_erro", 32'(bus.erro), 32'(rej || with_push));
        if (rej) begin
            check_stack("rej");
            return;
        end
        cf = 0;
        vf = 0;
        sa = (a >= HALF) ? a - FULL : a;
        sb = (b >= HALF) ? b - FULL : b;
        case (o)
            0: begin
                full = a + b;
                res  = full % FULL;
                cf   = full / FULL;
                vf   = ((sa + sb) > HALF - 1) || ((sa + sb) < -HALF);
            end
            1: begin
                res = (a - b + FULL) % FULL;
                cf  = (a < b);
                vf  = ((sa - sb) > HALF - 1) || ((sa - sb) < -HALF);
            end
            2: begin
                full = a * b;
                res  = full % FULL;
                vf   = (full >= FULL);
            end
            3: begin
                res   = a / b;
                mdl_r = ((a % b) != 0);
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            default: res = FULL - 1 - b;
        endcase
        repeat (need) void'(mdl_stk.pop_back());
        mdl_stk.push_back(res);
        exp_q.push_back(W'(res));
        lat      = 0;
        busy_cnt = 0;
        while (bus.res_valid !== 1'b1 && lat <= W + 4) begin
            if (bus.ocupado === 1'b1) busy_cnt++;
            @(negedge clock);
            lat++;
        end
        check("res_valid", 32'(bus.res_valid), 1);
        check("latency", lat, seq ? W + 1 : 1);
        check("ocupado_cycles", busy_cnt, seq ? W : 0);
        exp_res = exp_q.pop_front();
        check("resultado", 32'(bus.resultado), 32'(exp_res));
        check("cout", 32'(bus.cout), cf);
        check("ov", 32'(bus.ov), vf);
        check("zero", 32'(bus.zero), 32'(res == 0));
        check("resto_led", 32'(bus.resto_led), mdl_r);
        check_stack("op");
        @(negedge clock);
        check("res_valid_pulse", 32'(bus.res_valid), 0);
    endtask

    initial begin
        int rv_seen;
        bus.dado_in  = '0;
        bus.push     = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
`ifdef REUSO_EN
        bus.reuso    = 1'b0;
`endif

        // Basic add
        do_reset();
        do_push(7);
        do_push(5);
        run_op(0, 1'b0);

        // Carry and signed overflow
        do_reset();
        do_push(200);
        do_push(100);
        run_op(0, 1'b0);
        do_push(8'h7F);
        do_push(1);
        run_op(0, 1'b0);

        // Sequential multiply with upper-half overflow
        do_reset();
        do_push(20);
        do_push(13);
        run_op(2, 1'b0);

        // Divide with remainder, then divide by zero
        do_reset();
        do_push(17);
        do_push(5);
        run_op(3, 1'b0);
        do_push(9);
        do_push(0);
        run_op(3, 1'b0);

        // Full stack and underflow
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) do_push(i);
        do_reset();
        run_op(0, 1'b0);
        run_op(7, 1'b0);

        // Op and push in the same cycle: op proceeds, push refused
        do_reset();
        do_push(3);
        do_push(4);
        run_op(1, 1'b1);

        // Reset in the middle of a multiply
        do_reset();
        do_push(20);
        do_push(13);
        @(negedge clock);
        bus.op       = 3'd2;
        bus.op_valid = 1'b1;
        @(negedge clock);
        bus.op_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_mul_ocupado", 32'(bus.ocupado), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        mdl_stk.delete();
        exp_q.delete();
        mdl_r = 0;
        @(negedge clock);
        rst_n   = 1'b1;
        rv_seen = 0;
        repeat (W + 4) begin
            @(negedge clock);
            if (bus.res_valid === 1'b1) rv_seen++;
        end
        check("abort_no_res_valid", rv_seen, 0);
        check_stack("abort");

        // Random mix
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 4) do_push($urandom_range(0, FULL - 1));
            else run_op($urandom_range(0, 7), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ula_rpn_pilha.md
Name: ula_rpn_pilha

Overview:
Parametrised successor of the 8-bit RPN ALU core. It has a W-bit datapath, a DEPTH-entry operand stack with push/pop, and one shared sequential multiply/divide unit. Operations use a valid/ready handshake instead of a fixed 4-state enter sequence. The block sits between the debounced front-panel controls and the display/flag LEDs. It also serves as a reusable compute core for later FPGA projects.

Parameters:
W, 8, operand/result width in bits (>=4)
DEPTH, 4, stack entries (>=2)
NW, $clog2(DEPTH+1), width of the stack-level count

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
dado_in  in  W  operand to push
push  in  1  single-cycle push request (from debouncer)
op_valid  in  1  operation request
op  in  3  opcode, sampled when op_valid && op_ready
op_ready  out  1  high in IDLE only
res_valid  out  1  one-cycle pulse when a result is written to the stack
resultado  out  W  last result register
topo  out  W  current top of stack (0 when empty)
nivel  out  NW  number of valid entries
cout, ov, zero  out  1 each  flags of last result, held until next result
erro  out  1  one-cycle pulse on any rejected request
resto_led  out  1  last DIV had a nonzero remainder; held
ocupado  out  1  sequential op in progress

Behaviour:
- Reset (async, rst_n=0): stack cleared, nivel=0, topo=0, resultado=0, all flags=0, op_ready=1, res_valid=0, FSM=IDLE. Reset mid-operation aborts the MUL/DIV and nothing is pushed.
- Opcodes: 000 ADD, 001 SUB (A-B), 010 MUL (seq), 011 DIV (seq, quotient), 100 AND, 101 OR, 110 XOR, 111 NOT (unary on top).
  - B is the top entry; A is the entry below it.
  - Binary ops pop 2 and push 1. NOT pops 1 and pushes 1.
- Arithmetic and flags:
  - ADD: cout = carry out of W bits; ov = signed overflow.
  - SUB: cout = borrow.
  - MUL: low W bits kept; ov=1 if the upper W bits are nonzero.
  - DIV by 0: erro pulse; operands stay on the stack; no result.
  - zero = (result==0) for every op.
- FSM: IDLE, EXEC, WRITE.
  - IDLE: accept on op_valid && op_ready.
  - Combinational op: go to WRITE; the result is pushed on the next edge. Latency: accept at T, res_valid at T+1.
  - MUL/DIV: go to EXEC. Shift-add / restoring divide runs one bit per cycle for W cycles, then WRITE. res_valid at T+W+1. ocupado=1 from T+1 until res_valid.
  - WRITE: push result, load resultado and flags, pulse res_valid, return to IDLE.
- Push:
  - Accepted only in IDLE. If nivel<DEPTH, the entry is written and nivel increments.
  - If full: erro pulse, stack unchanged.
  - Push outside IDLE: ignored, erro pulse.
- Underflow: op needing more operands than nivel → erro pulse, stack unchanged, stay in IDLE.
- Simultaneous push and op_valid in IDLE: the op has priority; the push is rejected with erro.
- Operands are latched at accept. The stack stays frozen during EXEC.

Optional Feature:
REUSO_EN
- Defined: adds input `reuso` (1 bit). A pulse in IDLE pushes `resultado` onto the stack, with the same full rule as push. Priority order is op > reuso > push.
- Undefined: no port; the stack is fed only from dado_in.

Decomposition:
- Package ula_rpn_pkg:
  - opcode enum (OP_ADD..OP_NOT)
  - FSM state enum
  - flags struct {cout, ov, zero, resto}
  - helper function is_seq(op)
- Sub-module mult_div_seq, parametrised by W:
  - Inputs: start, modo (0 = MUL, 1 = DIV), A, B.
  - Outputs: done pulse, result, upper-half-nonzero flag, remainder-nonzero flag.
  - The stack is an inline register array.

Test Plan:
- Reset, then push 7, push 5, op=ADD → res_valid at T+1, resultado=12, nivel=1, zero=0, cout=0.
- W=8: push 200, push 100, ADD → resultado=44, cout=1; then push 0x7F, push 1, ADD → ov=1.
- Push 20, push 13, MUL → ocupado for 8 cycles, res_valid at T+9, resultado=4 (260 mod 256), ov=1.
- Push 17, push 5, DIV → resultado=3, resto_led=1. Push 9, push 0, DIV → erro pulse, nivel unchanged.
- Push DEPTH values, then a further push → erro, nivel=DEPTH. From empty, ADD → erro, nivel=0.
- Assert rst_n low at cycle 4 of a MUL → all outputs return to reset values immediately; no res_valid afterwards.
